// File: rtl/prll_bs_pkg.sv
// Shared types, defaults and the round-robin pick helper for the parallel
// round-robin broadcast/unicast bus arbiter.
package prll_bs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } lane_state_t;

    localparam logic [7:0] BRDCST_ID_DEF = 8'hFF;

    // Upper bound on drivers per lane handled by rr_pick.
    localparam int MAX_DRVRS = 64;

    // First pending index at or after ptr, wrapping modulo n.
    // Walking downwards lets the nearest candidate overwrite farther ones,
    // so no "found" flag is needed.
    function automatic int rr_pick(input logic [MAX_DRVRS-1:0] pndng,
                                   input int ptr,
                                   input int n);
        int idx;
        int pick;
        pick = 0;
        for (int i = MAX_DRVRS - 1; i >= 0; i--) begin
            if (i < n) begin
                idx = ptr + i;
                if (idx >= n) idx = idx - n;
                if (pndng[idx]) pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/prll_rr_bs_lane.sv
// One bus lane: round-robin grant over the drivers' FIFOs, pop of the winner,
// capture of its head word and unicast/broadcast routing into receive FIFOs.
// Optional per-lane transfer/drop counters when BS_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | wait for any pndng, pick winner from rr_ptr
//   POP   | pop strobe to winner, capture its head word
//   PUSH  | push captured word to destination(s), advance rr_ptr
module prll_rr_bs_lane
    import prll_bs_pkg::*;
#(
    parameter int              drvrs     = 8,
    parameter int              bits      = 32,
    parameter int              id_w      = 8,
    parameter logic [id_w-1:0] brdcst_id = id_w'(BRDCST_ID_DEF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [drvrs-1:0]      pndng,
    output logic [drvrs-1:0]      pop,
    input  logic [drvrs*bits-1:0] D_pop,
    output logic [drvrs-1:0]      push,
    output logic [bits-1:0]       D_push
`ifdef BS_STATS_EN
    ,
    output logic [15:0]           xfer_cnt,
    output logic [15:0]           drop_cnt
`endif
);

    localparam int PW = $clog2(drvrs);

    lane_state_t     state_q, state_d;
    logic [PW-1:0]   winner_q, winner_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [bits-1:0] word_q, word_d;
    logic [id_w-1:0] dest;
    logic            is_bcast;

    assign dest     = word_q[bits-1 -: id_w];
    assign is_bcast = (dest == brdcst_id);
    assign D_push   = word_q;

    // Lane registers: state, granted driver, round-robin pointer, captured word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            winner_q <= '0;
            rr_q     <= '0;
            word_q   <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            rr_q     <= rr_d;
            word_q   <= word_d;
        end
    end

    // Next-state, grant, pop strobe and word capture.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        rr_d     = rr_q;
        word_d   = word_q;
        pop      = '0;
        case (state_q)
            IDLE: begin
                if (|pndng) begin
                    winner_d = PW'(rr_pick(MAX_DRVRS'(pndng), int'(rr_q), drvrs));
                    state_d  = POP;
                end
            end
            POP: begin
                // pndng is not re-checked: the FIFO guarantees a valid head.
                for (int d = 0; d < drvrs; d++) begin
                    if (winner_q == PW'(d)) begin
                        pop[d] = 1'b1;
                        word_d = D_pop[d*bits +: bits];
                    end
                end
                state_d = PUSH;
            end
            PUSH: begin
                rr_d    = (winner_q == PW'(drvrs - 1)) ? '0 : winner_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Destination decode: broadcast skips the source, out-of-range IDs are dropped.
    always_comb begin
        push = '0;
        if (state_q == PUSH) begin
            for (int d = 0; d < drvrs; d++) begin
                if (is_bcast)
                    push[d] = (winner_q != PW'(d));
                else if (dest == id_w'(d))
                    push[d] = 1'b1;
            end
        end
    end

`ifdef BS_STATS_EN
    logic is_ucast;
    logic is_drop;

    // A destination is unicast when it matches one of the lane's drivers.
    always_comb begin
        is_ucast = 1'b0;
        for (int d = 0; d < drvrs; d++) begin
            if (dest == id_w'(d)) is_ucast = 1'b1;
        end
    end

    assign is_drop = !is_bcast && !is_ucast;

    // Completed transfers wrap; dropped words saturate.
    always_ff @(posedge clk) begin
        if (reset) begin
            xfer_cnt <= '0;
            drop_cnt <= '0;
        end else if (state_q == PUSH) begin
            xfer_cnt <= xfer_cnt + 16'd1;
            if (is_drop && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: rtl/prll_rr_bs_arbiter.sv
// N-bus x M-driver parallel round-robin bus arbiter with flattened ports.
// Each bus is an independent prll_rr_bs_lane; the lane's pushed word is
// replicated onto every driver slice of that bus.
// Optional macro BS_STATS_EN adds per-lane xfer_cnt/drop_cnt outputs.
module prll_rr_bs_arbiter
    import prll_bs_pkg::*;
#(
    parameter int              buses     = 1,
    parameter int              drvrs     = 8,
    parameter int              bits      = 32,
    parameter int              id_w      = 8,
    parameter logic [id_w-1:0] brdcst_id = id_w'(BRDCST_ID_DEF)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [buses*drvrs-1:0]      pndng,
    output logic [buses*drvrs-1:0]      pop,
    input  logic [buses*drvrs*bits-1:0] D_pop,
    output logic [buses*drvrs-1:0]      push,
    output logic [buses*drvrs*bits-1:0] D_push
`ifdef BS_STATS_EN
    ,
    output logic [buses*16-1:0]         xfer_cnt,
    output logic [buses*16-1:0]         drop_cnt
`endif
);

    for (genvar b = 0; b < buses; b++) begin : g_lane
        logic [bits-1:0] lane_word;

        prll_rr_bs_lane #(
            .drvrs     (drvrs),
            .bits      (bits),
            .id_w      (id_w),
            .brdcst_id (brdcst_id)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .pndng    (pndng[b*drvrs +: drvrs]),
            .pop      (pop[b*drvrs +: drvrs]),
            .D_pop    (D_pop[b*drvrs*bits +: drvrs*bits]),
            .push     (push[b*drvrs +: drvrs]),
            .D_push   (lane_word)
`ifdef BS_STATS_EN
            ,
            .xfer_cnt (xfer_cnt[b*16 +: 16]),
            .drop_cnt (drop_cnt[b*16 +: 16])
`endif
        );

        for (genvar d = 0; d < drvrs; d++) begin : g_slice
            assign D_push[(b*drvrs+d)*bits +: bits] = lane_word;
        end
    end

endmodule

// File: tb/tb_prll_rr_bs_arbiter.sv
// Self-checking bench for prll_rr_bs_arbiter with 2 buses x 8 drivers x 32 bits.
module tb_prll_rr_bs_arbiter;

    localparam int B = 2;
    localparam int N = 8;
    localparam int W = 32;

    logic             clk;
    logic             reset;
    logic [B*N-1:0]   pndng;
    logic [B*N-1:0]   pop;
    logic [B*N*W-1:0] D_pop;
    logic [B*N-1:0]   push;
    logic [B*N*W-1:0] D_push;
`ifdef BS_STATS_EN
    logic [B*16-1:0]  xfer_cnt;
    logic [B*16-1:0]  drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    prll_rr_bs_arbiter #(
        .buses (B),
        .drvrs (N),
        .bits  (W),
        .id_w  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pndng    (pndng),
        .pop      (pop),
        .D_pop    (D_pop),
        .push     (push),
        .D_push   (D_push)
`ifdef BS_STATS_EN
        ,
        .xfer_cnt (xfer_cnt),
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pndng = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Receive mask a word from driver src must produce on an 8-driver bus.
    function automatic logic [7:0] route(input logic [31:0] w, input int src);
        logic [7:0] dest;
        logic [7:0] m;
        dest = w[31:24];
        m    = 8'h00;
        if (dest == 8'hFF) begin
            m = 8'hFF;
            m[src] = 1'b0;
        end else if (dest < 8'd8) begin
            m[dest[2:0]] = 1'b1;
        end
        return m;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        pndng = '1;
        for (int i = 0; i < B*N; i++) D_pop[i*W +: W] = $urandom;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (pop !== '0) begin n_fail++; $display("FAIL reset_pop cyc%0d got=%h exp=0", c, pop); end
            n_checks++;
            if (push !== '0) begin n_fail++; $display("FAIL reset_push cyc%0d got=%h exp=0", c, push); end
            n_checks++;
            if (D_push !== '0) begin n_fail++; $display("FAIL reset_dpush cyc%0d got=%h exp=0", c, D_push[63:0]); end
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (pop !== 16'h0101) begin n_fail++; $display("FAIL release_pop got=%h exp=0101", pop); end
        // Reset while in POP: word discarded, pointer back to 0.
        reset = 1'b1;
        tick();
        n_checks++;
        if (pop !== '0 || push !== '0) begin
            n_fail++; $display("FAIL midop_reset got pop=%h push=%h exp=0/0", pop, push);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if (pop !== 16'h0101) begin n_fail++; $display("FAIL midop_rrptr got=%h exp=0101", pop); end
        pndng = '0;
    endtask

    task automatic test_unicast();
        do_reset();
        D_pop[2*W +: W] = 32'h0500ABCD;
        pndng = 16'h0004;
        tick();
        n_checks++;
        if (pop !== 16'h0004 || push !== '0) begin
            n_fail++; $display("FAIL uni_pop got pop=%h push=%h exp=0004/0000", pop, push);
        end
        pndng = '0;
        tick();
        n_checks++;
        if (push !== 16'h0020 || pop !== '0) begin
            n_fail++; $display("FAIL uni_push got push=%h pop=%h exp=0020/0000", push, pop);
        end
        n_checks++;
        if (D_push[N*W-1:0] !== {N{32'h0500ABCD}}) begin
            n_fail++; $display("FAIL uni_data got=%h exp=0500abcd", D_push[W-1:0]);
        end
        tick();
        n_checks++;
        if (push !== '0) begin n_fail++; $display("FAIL uni_oneshot got=%h exp=0", push); end
    endtask

    task automatic test_broadcast();
        do_reset();
        D_pop[3*W +: W] = 32'hFF123456;
        pndng = 16'h0008;
        tick();
        n_checks++;
        if (pop !== 16'h0008) begin n_fail++; $display("FAIL bc_pop got=%h exp=0008", pop); end
        pndng = '0;
        tick();
        n_checks++;
        if (push !== 16'h00F7) begin n_fail++; $display("FAIL bc_push got=%h exp=00f7", push); end
        n_checks++;
        if (D_push[N*W-1:0] !== {N{32'hFF123456}}) begin
            n_fail++; $display("FAIL bc_data got=%h exp=ff123456", D_push[7*W +: W]);
        end
        tick();
        n_checks++;
        if (push !== '0) begin n_fail++; $display("FAIL bc_oneshot got=%h exp=0", push); end
    endtask

    task automatic test_drop();
        do_reset();
        D_pop[1*W +: W] = 32'h09ABCDEF;
        pndng = 16'h0002;
        tick();
        n_checks++;
        if (pop !== 16'h0002) begin n_fail++; $display("FAIL drop_pop got=%h exp=0002", pop); end
        pndng = '0;
        tick();
        n_checks++;
        if (push !== '0 || pop !== '0) begin
            n_fail++; $display("FAIL drop_push got push=%h pop=%h exp=0/0", push, pop);
        end
        tick();
`ifdef BS_STATS_EN
        n_checks++;
        if (drop_cnt !== 32'h0000_0001) begin n_fail++; $display("FAIL drop_cnt got=%h exp=00000001", drop_cnt); end
        n_checks++;
        if (xfer_cnt !== 32'h0000_0001) begin n_fail++; $display("FAIL xfer_cnt got=%h exp=00000001", xfer_cnt); end
`endif
    endtask

    task automatic test_round_robin();
        logic [31:0] words [N];
        logic [7:0]  exp_m;
        do_reset();
        for (int d = 0; d < N; d++) begin
            words[d] = {8'((d + 3) % N), 24'($urandom)};
            D_pop[d*W +: W] = words[d];
        end
        pndng = 16'h00FF;
        for (int k = 0; k < 17; k++) begin
            tick();
            n_checks++;
            if (pop !== 16'(1 << (k % N))) begin
                n_fail++; $display("FAIL rr_grant k=%0d got=%h exp=%h", k, pop, 16'(1 << (k % N)));
            end
            tick();
            exp_m = route(words[k % N], k % N);
            n_checks++;
            if (push !== {8'h00, exp_m} || D_push[N*W-1:0] !== {N{words[k % N]}}) begin
                n_fail++; $display("FAIL rr_push k=%0d got=%h exp=%h", k, push, {8'h00, exp_m});
            end
            tick();
            n_checks++;
            if (pop !== '0 || push !== '0) begin
                n_fail++; $display("FAIL rr_idle k=%0d got pop=%h push=%h exp=0/0", k, pop, push);
            end
        end
        pndng = '0;
    endtask

    task automatic test_multi_bus_random();
        int          ph   [B];
        int          ptr  [B];
        int          win  [B];
        logic [31:0] wd   [B];
        int          xfer [B];
        int          drop [B];
        logic [15:0] exp_pop;
        logic [15:0] exp_push;
        logic [7:0]  m;
        logic [7:0]  dst;
        int          r;
        int          idx;
        bit          found;
        do_reset();
        for (int b = 0; b < B; b++) begin
            ph[b] = 0; ptr[b] = 0; win[b] = 0; wd[b] = '0; xfer[b] = 0; drop[b] = 0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int b = 0; b < B; b++) begin
                pndng[b*N +: N] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
                for (int d = 0; d < N; d++) begin
                    r = $urandom_range(0, 9);
                    if (r < 8)       dst = 8'(r);
                    else if (r == 8) dst = 8'hFF;
                    else             dst = 8'($urandom_range(8, 254));
                    D_pop[(b*N+d)*W +: W] = {dst, 24'($urandom)};
                end
            end
            // Reference: each lane spends one cycle each in grant, pop, push.
            for (int b = 0; b < B; b++) begin
                case (ph[b])
                    0: begin
                        found = 0;
                        for (int i = 0; i < N; i++) begin
                            idx = (ptr[b] + i) % N;
                            if (!found && pndng[b*N + idx]) begin win[b] = idx; found = 1; end
                        end
                        if (found) ph[b] = 1;
                    end
                    1: begin
                        wd[b] = D_pop[(b*N + win[b])*W +: W];
                        ph[b] = 2;
                    end
                    default: begin
                        xfer[b]++;
                        if (wd[b][31:24] != 8'hFF && wd[b][31:24] >= 8'd8) drop[b]++;
                        ptr[b] = (win[b] + 1) % N;
                        ph[b] = 0;
                    end
                endcase
            end
            tick();
            exp_pop  = '0;
            exp_push = '0;
            for (int b = 0; b < B; b++) begin
                if (ph[b] == 1) exp_pop[b*N + win[b]] = 1'b1;
                if (ph[b] == 2) begin
                    m = route(wd[b], win[b]);
                    exp_push[b*N +: N] = m;
                end
            end
            n_checks++;
            if (pop !== exp_pop) begin
                n_fail++; $display("FAIL mb_pop cyc=%0d got=%h exp=%h", cyc, pop, exp_pop);
            end
            n_checks++;
            if (push !== exp_push) begin
                n_fail++; $display("FAIL mb_push cyc=%0d got=%h exp=%h", cyc, push, exp_push);
            end
            for (int b = 0; b < B; b++) begin
                if (ph[b] == 2) begin
                    n_checks++;
                    if (D_push[b*N*W +: N*W] !== {N{wd[b]}}) begin
                        n_fail++; $display("FAIL mb_data cyc=%0d lane=%0d got=%h exp=%h",
                                           cyc, b, D_push[b*N*W +: W], wd[b]);
                    end
                end
            end
        end
        pndng = '0;
        tick();
        tick();
        tick();
        // Let both lanes drain any transaction that was in flight.
        for (int b = 0; b < B; b++) begin
            if (ph[b] == 1) begin xfer[b]++; wd[b] = D_pop[(b*N + win[b])*W +: W];
                if (wd[b][31:24] != 8'hFF && wd[b][31:24] >= 8'd8) drop[b]++; end
            else if (ph[b] == 2) begin xfer[b]++;
                if (wd[b][31:24] != 8'hFF && wd[b][31:24] >= 8'd8) drop[b]++; end
        end
`ifdef BS_STATS_EN
        for (int b = 0; b < B; b++) begin
            n_checks++;
            if (xfer_cnt[b*16 +: 16] !== 16'(xfer[b])) begin
                n_fail++; $display("FAIL mb_xfer lane=%0d got=%0d exp=%0d", b, xfer_cnt[b*16 +: 16], xfer[b]);
            end
            n_checks++;
            if (drop_cnt[b*16 +: 16] !== 16'(drop[b])) begin
                n_fail++; $display("FAIL mb_drop lane=%0d got=%0d exp=%0d", b, drop_cnt[b*16 +: 16], drop[b]);
            end
        end
`endif
    endtask

    initial begin
        clk   = 1'b0;
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;
        test_reset();
        test_unicast();
        test_broadcast();
        test_drop();
        test_round_robin();
        test_multi_bus_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
